// File: rtl/alarma_multizona.sv
`default_nettype none
// ============================================================================
// Module   : alarma_multizona
// Brief    : N-zone intruder alarm controller with exit/entry delays, timed
//            siren and lockout; latches triggering zones and counts alarms.
// Revision : 1.0 - initial release
// ============================================================================
module alarma_multizona #(
    parameter int N_ZONAS    = 4,
    parameter int ANCHO_CONT = 8,
    parameter int T_SALIDA   = 29,
    parameter int T_ENTRADA  = 15,
    parameter int T_SIRENA   = 63,
    parameter int ANCHO_EV   = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                inicio_i,
    input  logic [N_ZONAS-1:0]  intruso_i,
    input  logic [N_ZONAS-1:0]  zona_hab_i,
    input  logic [N_ZONAS-1:0]  zona_inm_i,
    output logic                sirena_o,
    output logic                aviso_o,
    output logic                armada_o,
    output logic [N_ZONAS-1:0]  zona_disparo_o,
    output logic [ANCHO_EV-1:0] n_alarmas_o,
    output logic [2:0]          estado_o
);

    localparam logic [2:0] c_INICIAL   = 3'd0;
    localparam logic [2:0] c_ESPERA    = 3'd1;
    localparam logic [2:0] c_ACTIVADA  = 3'd2;
    localparam logic [2:0] c_PREALARMA = 3'd3;
    localparam logic [2:0] c_ALARMA    = 3'd4;
    localparam logic [2:0] c_BLOQUEO   = 3'd5;

    localparam int                  c_T_MAX   = (1 << ANCHO_CONT) - 1;
    localparam logic [ANCHO_CONT-1:0] c_T_SAL = ANCHO_CONT'(T_SALIDA);
    localparam logic [ANCHO_CONT-1:0] c_T_ENT = ANCHO_CONT'(T_ENTRADA);
    localparam logic [ANCHO_CONT-1:0] c_T_SIR = ANCHO_CONT'(T_SIRENA);
    localparam logic [ANCHO_EV-1:0]   c_EV_MAX = {ANCHO_EV{1'b1}};

    generate
        if (T_SALIDA > c_T_MAX || T_ENTRADA > c_T_MAX || T_SIRENA > c_T_MAX) begin : g_chk_tiempos
            $error("alarma_multizona: a T_* delay does not fit in ANCHO_CONT bits");
        end
    endgenerate

    logic [2:0]            state_q, state_d;
    logic [ANCHO_CONT-1:0] cnt_q, cnt_d;
    logic [N_ZONAS-1:0]    zd_q, zd_d;
    logic [ANCHO_EV-1:0]   nal_q, nal_d;
    logic                  sirena_q, sirena_d;
    logic                  aviso_q, aviso_d;
    logic                  armada_q, armada_d;

    logic [N_ZONAS-1:0] w_act;
    logic               w_disp;
    logic               w_inm;
    logic               w_cuenta;
    logic               w_registra;

    assign w_act  = intruso_i & zona_hab_i;
    assign w_disp = |w_act;
    assign w_inm  = |(w_act & zona_inm_i);

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= c_INICIAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; disarm overrides every other transition
    always_comb begin
        state_d = state_q;
        if (!inicio_i) begin
            state_d = c_INICIAL;
        end else begin
            case (state_q)
                c_INICIAL:   state_d = c_ESPERA;
                c_ESPERA:    if (cnt_q == c_T_SAL) state_d = c_ACTIVADA;
                c_ACTIVADA: begin
                    if (w_inm)       state_d = c_ALARMA;
                    else if (w_disp) state_d = c_PREALARMA;
                end
                c_PREALARMA: if (w_inm || cnt_q == c_T_ENT) state_d = c_ALARMA;
                c_ALARMA:    if (cnt_q == c_T_SIR) state_d = w_disp ? c_BLOQUEO : c_ACTIVADA;
                c_BLOQUEO:   if (!w_disp) state_d = c_ACTIVADA;
                default:     state_d = c_INICIAL;
            endcase
        end
    end

    // Output logic, computed from the next state so registered outputs track estado
    always_comb begin
        sirena_d = (state_d == c_ALARMA);
        aviso_d  = (state_d == c_PREALARMA);
        armada_d = (state_d == c_ACTIVADA) || (state_d == c_PREALARMA) ||
                   (state_d == c_ALARMA)   || (state_d == c_BLOQUEO);
    end

    assign w_cuenta   = (state_q == c_ESPERA) || (state_q == c_PREALARMA) || (state_q == c_ALARMA);
    assign w_registra = (state_q == c_ACTIVADA) || (state_q == c_PREALARMA) || (state_q == c_ALARMA);

    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && w_cuenta) begin
            cnt_d = cnt_q + ANCHO_CONT'(1);
        end

        zd_d  = zd_q;
        nal_d = nal_q;
        if (state_q == c_INICIAL && state_d == c_ESPERA) begin
            zd_d  = '0;
            nal_d = '0;
        end else begin
            if (w_registra) begin
                zd_d = zd_q | w_act;
            end
            if (state_d == c_ALARMA && state_q != c_ALARMA && nal_q != c_EV_MAX) begin
                nal_d = nal_q + ANCHO_EV'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            zd_q     <= '0;
            nal_q    <= '0;
            sirena_q <= 1'b0;
            aviso_q  <= 1'b0;
            armada_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            zd_q     <= zd_d;
            nal_q    <= nal_d;
            sirena_q <= sirena_d;
            aviso_q  <= aviso_d;
            armada_q <= armada_d;
        end
    end

    assign sirena_o       = sirena_q;
    assign aviso_o        = aviso_q;
    assign armada_o       = armada_q;
    assign zona_disparo_o = zd_q;
    assign n_alarmas_o    = nal_q;
    assign estado_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alarma_multizona.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarma_multizona
// Brief    : Directed and random stimulus for alarma_multizona against a
//            time-remaining behavioural model of the alarm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarma_multizona;

    localparam int N  = 4;
    localparam int TS = 29;
    localparam int TE = 15;
    localparam int TA = 63;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inicio = 1'b0;
    logic [3:0] intruso = '0;
    logic [3:0] hab = '0;
    logic [3:0] inm = '0;
    logic       sirena, aviso, armada;
    logic [3:0] zdisp;
    logic [3:0] nal;
    logic [2:0] estado;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase number, cycles left in a timed phase, latched zones, alarm count
    int       m_st   = 0;
    int       m_left = 0;
    logic [3:0] m_zd = '0;
    int       m_nal  = 0;

    alarma_multizona #(
        .N_ZONAS(N), .ANCHO_CONT(8), .T_SALIDA(TS), .T_ENTRADA(TE), .T_SIRENA(TA), .ANCHO_EV(4)
    ) dut (
        .clock_i(clk), .reset_i(rst), .inicio_i(inicio), .intruso_i(intruso),
        .zona_hab_i(hab), .zona_inm_i(inm), .sirena_o(sirena), .aviso_o(aviso),
        .armada_o(armada), .zona_disparo_o(zdisp), .n_alarmas_o(nal), .estado_o(estado)
    );

    always #5 clk = ~clk;

    function automatic int duracion(input int st);
        case (st)
            1:       return TS;
            3:       return TE;
            4:       return TA;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] act;
        int ns;
        act = intruso & hab;
        if (rst) begin
            m_st = 0; m_left = 0; m_zd = '0; m_nal = 0;
            return;
        end
        ns = m_st;
        if (!inicio) ns = 0;
        else if (m_st == 0) ns = 1;
        else if (m_st == 1 && m_left == 0) ns = 2;
        else if (m_st == 2 && (act & inm) != 0) ns = 4;
        else if (m_st == 2 && act != 0) ns = 3;
        else if (m_st == 3 && ((act & inm) != 0 || m_left == 0)) ns = 4;
        else if (m_st == 4 && m_left == 0) ns = (act != 0) ? 5 : 2;
        else if (m_st == 5 && act == 0) ns = 2;

        if (m_st >= 2 && m_st <= 4) m_zd = m_zd | act;
        if (m_st == 0 && ns == 1) begin
            m_zd = '0; m_nal = 0;
        end
        if (ns == 4 && m_st != 4 && m_nal < 15) m_nal++;
        if (ns != m_st) m_left = duracion(ns);
        else if (m_left > 0) m_left--;
        m_st = ns;
    endtask

    task automatic compare();
        n_vec++;
        if (estado !== 3'(m_st)) begin
            n_err++; $display("FAIL estado: got %0d expected %0d at %0t", estado, m_st, $time);
        end
        if (sirena !== (m_st == 4)) begin
            n_err++; $display("FAIL sirena: got %0b expected %0b at %0t", sirena, m_st == 4, $time);
        end
        if (aviso !== (m_st == 3)) begin
            n_err++; $display("FAIL aviso: got %0b expected %0b at %0t", aviso, m_st == 3, $time);
        end
        if (armada !== (m_st >= 2 && m_st <= 5)) begin
            n_err++; $display("FAIL armada: got %0b expected %0b at %0t", armada, m_st >= 2, $time);
        end
        if (zdisp !== m_zd) begin
            n_err++; $display("FAIL zona_disparo: got %b expected %b at %0t", zdisp, m_zd, $time);
        end
        if (nal !== 4'(m_nal)) begin
            n_err++; $display("FAIL n_alarmas: got %0d expected %0d at %0t", nal, m_nal, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic lit(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++; $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_state(input int s, input int max);
        int k = 0;
        while (m_st != s && k < max) begin
            tick(); k++;
        end
        if (m_st != s) begin
            n_err++; $display("FAIL timeout waiting for state %0d: got %0d", s, m_st);
        end
    endtask

    task automatic arm();
        rst = 1'b1; inicio = 1'b0; intruso = '0; tick();
        rst = 1'b0; inicio = 1'b1; tick();
        wait_state(2, 100);
    endtask

    initial begin
        hab = 4'hF; inm = 4'h0;
        ticks(2);
        lit("reset estado", estado, 0);
        lit("reset zona_disparo", zdisp, 0);

        // Arming, with a zone active during the exit delay
        rst = 1'b0; inicio = 1'b1; intruso = 4'b0001;
        tick();
        lit("espera entry", estado, 1);
        ticks(10);
        intruso = '0;
        ticks(19);
        lit("espera last cycle", estado, 1);
        tick();
        lit("activada after 30", estado, 2);
        lit("armada", armada, 1);
        lit("sirena idle", sirena, 0);

        // Delayed zone
        intruso = 4'b0010; tick(); intruso = '0;
        lit("prealarma", estado, 3);
        lit("aviso", aviso, 1);
        ticks(15);
        lit("prealarma last", estado, 3);
        tick();
        lit("alarma sirena", sirena, 1);
        ticks(63);
        lit("alarma last", estado, 4);
        tick();
        lit("back to activada", estado, 2);
        lit("zona_disparo delayed", zdisp, 4'b0010);
        lit("n_alarmas one", nal, 1);

        // Immediate zone during pre-alarm
        inm = 4'b1000;
        intruso = 4'b0010; tick(); intruso = '0;
        ticks(4);
        intruso = 4'b1000; tick(); intruso = '0;
        lit("inmediata sirena", sirena, 1);
        lit("inmediata zonas", zdisp, 4'b1010);
        inm = 4'h0;

        // Lockout
        arm();
        intruso = 4'b0100;
        wait_state(5, 200);
        lit("bloqueo estado", estado, 5);
        lit("bloqueo sirena", sirena, 0);
        intruso = '0; tick();
        lit("bloqueo release", estado, 2);

        // Disarm on the last siren cycle with a zone active
        intruso = 4'b0100;
        wait_state(4, 100);
        for (int k = 0; k < 100 && m_left != 0; k++) tick();
        inicio = 1'b0; tick();
        lit("disarm estado", estado, 0);
        lit("disarm sirena", sirena, 0);
        lit("disarm zonas kept", zdisp, 4'b0100);
        intruso = '0; inicio = 1'b1; tick();
        lit("rearm zonas", zdisp, 0);
        lit("rearm n_alarmas", nal, 0);
        wait_state(2, 100);

        // Masked zone
        hab = 4'b1110; inm = 4'hF; intruso = 4'b0001;
        ticks(5);
        lit("masked zone", estado, 2);
        intruso = '0; hab = 4'hF;

        // Saturation of the alarm counter
        for (int a = 0; a < 17; a++) begin
            wait_state(2, 200);
            intruso = 4'b0001; tick(); intruso = '0;
        end
        wait_state(2, 200);
        lit("n_alarmas saturated", nal, 15);
        intruso = 4'b0001; tick(); intruso = '0;
        ticks(5);
        rst = 1'b1; tick(); rst = 1'b0;
        lit("reset in alarma estado", estado, 0);
        lit("reset in alarma sirena", sirena, 0);
        lit("reset in alarma zonas", zdisp, 0);
        lit("reset in alarma n_alarmas", nal, 0);

        // Random operation
        inicio = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst    = ($urandom_range(0, 499) == 0);
            inicio = ($urandom_range(0, 149) != 0);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 24) == 0) intruso[b] = ~intruso[b];
            if ($urandom_range(0, 99) == 0) hab = 4'($urandom);
            if ($urandom_range(0, 99) == 0) inm = 4'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarma_multizona.md
Name: alarma_multizona

Overview:
- Parametrised successor of the single-zone intruder alarm controller.
- Supports N zones with per-zone enable and per-zone immediate/delayed mode.
- Provides a separate exit delay, entry (pre-alarm) delay and maximum siren duration, followed by a lockout that prevents an endless siren.
- Sits between the keypad/zone-sensor synchronisers and the siren driver. Exposes latched triggering zones and an alarm-event count for the status display.

Parameters:
- N_ZONAS, 4: number of sensor zones.
- ANCHO_CONT, 8: width of the shared delay counter. All T_* values must be ≤ 2^ANCHO_CONT−1; this is checked at elaboration.
- T_SALIDA, 29: exit delay. ESPERA lasts T_SALIDA+1 cycles.
- T_ENTRADA, 15: entry delay. PREALARMA lasts at most T_ENTRADA+1 cycles.
- T_SIRENA, 63: siren duration. ALARMA lasts T_SIRENA+1 cycles.
- ANCHO_EV, 4: width of the alarm-event counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- inicio  in  1  arm request; 0 = disarm (highest priority).
- intruso  in  N_ZONAS  zone sensor levels, already synchronised; 1 = intrusion.
- zona_hab  in  N_ZONAS  zone enable; disabled zones are ignored.
- zona_inm  in  N_ZONAS  1 = immediate zone (no entry delay).
- sirena  out  1  siren drive.
- aviso  out  1  pre-alarm buzzer (entry delay running).
- armada  out  1  system armed (ACTIVADA, PREALARMA, ALARMA or BLOQUEO).
- zona_disparo  out  N_ZONAS  sticky record of zones that fired since the last arming.
- n_alarmas  out  ANCHO_EV  saturating count of ALARMA entries since the last arming.
- estado  out  3  current state code.

Behaviour:
Derived signals (combinational):
- act = intruso & zona_hab
- disp = |act
- inm = |(act & zona_inm)

Reset: while reset is high at a clock edge:
- state = INICIAL, counter = 0.
- All outputs 0; zona_disparo = 0, n_alarmas = 0.

State codes: INICIAL=0, ESPERA=1, ACTIVADA=2, PREALARMA=3, ALARMA=4, BLOQUEO=5. Codes 6 and 7 go to INICIAL on the next edge.

Global rule: inicio=0 in any state moves to INICIAL on the next edge. This overrides every other transition.

Counter:
- Cleared to 0 on every state change and while in INICIAL, ACTIVADA or BLOQUEO.
- Increments by 1 each cycle in ESPERA, PREALARMA and ALARMA; no wrap is possible given the parameter check.
- "exp_X" means counter == T_X.

Transitions:
- INICIAL: inicio → ESPERA. On this transition zona_disparo and n_alarmas are cleared.
- ESPERA: exp_SALIDA → ACTIVADA. Zone inputs are ignored.
- ACTIVADA: inm → ALARMA; else disp → PREALARMA; else stay.
- PREALARMA: inm or exp_ENTRADA → ALARMA; else stay. A zone clearing does not cancel the pre-alarm.
- ALARMA: at exp_SIRENA, disp → BLOQUEO, else → ACTIVADA.
- BLOQUEO: !disp → ACTIVADA; else stay.

Outputs (all registered, Moore-style, derived from the next state so they align with estado):
- sirena = (state == ALARMA).
- aviso = (state == PREALARMA).
- armada = state in {2,3,4,5}.
- estado = state code.

zona_disparo:
- In ACTIVADA, PREALARMA and ALARMA: zona_disparo ← zona_disparo | act every cycle.
- Held in all other states, including after disarm, so the display can read it.

n_alarmas: increments on each entry into ALARMA and saturates at 2^ANCHO_EV−1.

Latency: an immediate zone asserted at edge k while in ACTIVADA gives sirena=1 after edge k+1, i.e. one cycle.

Simultaneous events:
- disarm beats everything.
- inm beats exp_ENTRADA (both lead to ALARMA anyway).
- exp_SIRENA with disp=1 → BLOQUEO.

Reset mid-operation: any state returns to INICIAL with all outputs 0, including zona_disparo.

Test Plan:
- Arming: reset, then inicio=1 held → estado=1 for exactly 30 cycles, then estado=2, armada=1, sirena=0. Intrusion on zone 0 during ESPERA → no effect.
- Delayed zone: armed, intruso=4'b0010 for 1 cycle, zona_hab=4'hF, zona_inm=0 → estado=3, aviso=1 for 16 cycles, then sirena=1 for 64 cycles, zona_disparo=4'b0010, n_alarmas=1. Afterwards estado=2 (zone clear).
- Immediate zone during pre-alarm: zone 1 delayed fires; 5 cycles later zone 3 (zona_inm[3]=1) fires → sirena=1 on the next cycle, zona_disparo=4'b1010.
- Lockout: zone 2 held active through the whole ALARMA → after 64 cycles estado=5, sirena=0. Release zone 2 → estado=2 on the next cycle.
- Disarm priority: inicio=0 in the same cycle the counter reaches T_SIRENA with disp=1 → estado=0, sirena=0, zona_disparo retained. Re-arm → zona_disparo=0, n_alarmas=0.
- Masking and saturation: zona_hab[0]=0, intruso[0]=1 → no response. Then trigger 17 alarms (ANCHO_EV=4) → n_alarmas stops at 15. Apply reset during ALARMA → all outputs 0 after the edge.
